// File: rtl/arbiter_lru_n.sv
// N-requester least-recently-granted arbiter with one-hot grant and binary grant ID.
// Optional grant lock released by done, with an optional hold-timeout watchdog.
module arbiter_lru_n #(
  parameter int N        = 4,
  parameter int IDW      = $clog2(N),
  parameter int LOCK     = 1,
  parameter int MAX_HOLD = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           timeout,
  output logic           o_state   // 0 = IDLE, 1 = BUSY
);

  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t         r_state;
  logic [N-1:0]   r_gnt;
  logic           r_gnt_valid;
  logic [IDW-1:0] r_gnt_id;
  logic           r_timeout;
  logic [HCW-1:0] r_hold;
  logic [IDW-1:0] r_ord [N];

  logic           w_found;
  logic [IDW-1:0] w_k;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_ord_next [N];

  // Scan priority list from the top; the winner moves to the tail, the rest close the gap.
  always_comb begin
    w_found = 1'b0;
    w_k     = '0;
    w_win   = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && req[r_ord[k]]) begin
        w_found = 1'b1;
        w_k     = IDW'(k);
        w_win   = r_ord[k];
      end
    end
    for (int j = 0; j < N - 1; j++) begin
      if (j >= int'(w_k)) w_ord_next[j] = r_ord[j+1];
      else                w_ord_next[j] = r_ord[j];
    end
    w_ord_next[N-1] = w_found ? w_win : r_ord[N-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_timeout   <= 1'b0;
      r_hold      <= '0;
      for (int i = 0; i < N; i++) r_ord[i] <= IDW'(i);
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en && w_found) begin
            r_gnt       <= {{(N-1){1'b0}}, 1'b1} << w_win;
            r_gnt_valid <= 1'b1;
            r_gnt_id    <= w_win;
            r_state     <= S_BUSY;
            r_hold      <= HCW'(1);
            r_ord       <= w_ord_next;
          end else begin
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
          end
        end
        S_BUSY: begin
          // done wins over a coincident watchdog expiry, so timeout stays low then.
          if (LOCK == 0 || done) begin
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_state     <= S_IDLE;
          end else if (MAX_HOLD != 0 && r_hold == HCW'(MAX_HOLD)) begin
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_state     <= S_IDLE;
            r_timeout   <= 1'b1;
          end else if (r_hold != {HCW{1'b1}}) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign gnt_id    = r_gnt_id;
  assign timeout   = r_timeout;
  assign o_state   = r_state;

endmodule

// File: tb/tb_arbiter_lru_n.sv
// Bench for arbiter_lru_n: three configurations (pulse, lock, lock+watchdog) driven
// by shared stimulus and compared against a cycle model through an expected queue.
module tb_arbiter_lru_n;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] req;
  logic       done;

  logic [3:0] gnt0, gnt1, gnt2;
  logic       val0, val1, val2;
  logic [1:0] id0, id1, id2;
  logic       to0, to1, to2;
  logic       st0, st1, st2;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-DUT packed view: {state, timeout, valid, id[1:0], gnt[3:0]}
  logic [26:0] exp_q[$];

  // Reference model state, one slot per DUT
  int         m_ord  [3][4];
  logic       m_busy [3];
  int         m_hold [3];
  logic [3:0] m_gnt  [3];
  logic [1:0] m_id   [3];
  logic       m_to   [3];
  int         lock_p [3] = '{0, 1, 1};
  int         maxh_p [3] = '{0, 0, 3};

  arbiter_lru_n #(.N(4), .LOCK(0), .MAX_HOLD(0)) u_dut0 (
    .clk(clk), .reset(reset), .en(en), .req(req), .done(done),
    .gnt(gnt0), .gnt_valid(val0), .gnt_id(id0), .timeout(to0), .o_state(st0));

  arbiter_lru_n #(.N(4), .LOCK(1), .MAX_HOLD(0)) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .req(req), .done(done),
    .gnt(gnt1), .gnt_valid(val1), .gnt_id(id1), .timeout(to1), .o_state(st1));

  arbiter_lru_n #(.N(4), .LOCK(1), .MAX_HOLD(3)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .req(req), .done(done),
    .gnt(gnt2), .gnt_valid(val2), .gnt_id(id2), .timeout(to2), .o_state(st2));

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic release_grant(input int dd);
    m_busy[dd] = 1'b0;
    m_gnt[dd]  = 4'b0;
    m_id[dd]   = 2'd0;
  endtask

  task automatic model_step(input int dd, input logic rst, input logic e,
                            input logic [3:0] r, input logic d, output logic [8:0] o);
    int k;
    int w;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_ord[dd][i] = i;
      m_busy[dd] = 1'b0;
      m_hold[dd] = 0;
      m_gnt[dd]  = 4'b0;
      m_id[dd]   = 2'd0;
      m_to[dd]   = 1'b0;
    end else begin
      m_to[dd] = 1'b0;
      if (!m_busy[dd]) begin
        k = -1;
        if (e) begin
          for (int i = 3; i >= 0; i--) if (r[m_ord[dd][i]]) k = i;
        end
        if (k >= 0) begin
          w = m_ord[dd][k];
          for (int j = k; j < 3; j++) m_ord[dd][j] = m_ord[dd][j+1];
          m_ord[dd][3] = w;
          m_gnt[dd]  = 4'b0001 << w;
          m_id[dd]   = w[1:0];
          m_busy[dd] = 1'b1;
          m_hold[dd] = 1;
        end else begin
          m_gnt[dd] = 4'b0;
          m_id[dd]  = 2'd0;
        end
      end else if (lock_p[dd] == 0 || d) begin
        release_grant(dd);
      end else if (maxh_p[dd] != 0 && m_hold[dd] == maxh_p[dd]) begin
        release_grant(dd);
        m_to[dd] = 1'b1;
      end else begin
        m_hold[dd] = m_hold[dd] + 1;
      end
    end
    o = {m_busy[dd], m_to[dd], |m_gnt[dd], m_id[dd], m_gnt[dd]};
  endtask

  task automatic compare_dut(input int dd, input logic [8:0] got, input logic [8:0] exp);
    check($sformatf("d%0d_gnt", dd),   got[3:0], exp[3:0]);
    check($sformatf("d%0d_id", dd),    got[5:4], exp[5:4]);
    check($sformatf("d%0d_valid", dd), got[6],   exp[6]);
    check($sformatf("d%0d_tout", dd),  got[7],   exp[7]);
    check($sformatf("d%0d_state", dd), got[8],   exp[8]);
  endtask

  // Driver: apply one cycle of inputs, push model expectation, sample after the edge.
  task automatic step(input logic rst, input logic e, input logic [3:0] r, input logic d);
    logic [8:0]  o0, o1, o2;
    logic [26:0] ex;
    reset = rst;
    en    = e;
    req   = r;
    done  = d;
    model_step(0, rst, e, r, d, o0);
    model_step(1, rst, e, r, d, o1);
    model_step(2, rst, e, r, d, o2);
    exp_q.push_back({o2, o1, o0});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      ex = exp_q.pop_front();
      compare_dut(0, {st0, to0, val0, id0, gnt0}, ex[8:0]);
      compare_dut(1, {st1, to1, val1, id1, gnt1}, ex[17:9]);
      compare_dut(2, {st2, to2, val2, id2, gnt2}, ex[26:18]);
    end
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    req   = 4'b0;
    done  = 1'b0;
    #1;

    // Reset state
    step(1, 0, 4'b0, 0);
    step(1, 0, 4'b0, 0);
    check("rst_gnt", {gnt2, gnt1, gnt0}, 12'h000);
    check("rst_val", {val2, val1, val0}, 3'b000);

    // Round robin under full request, grant pulses on alternate cycles
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 4'b1111, 0);
      if (i % 2 == 0) begin
        check("t1_id", id0, (i / 2) % 4);
        check("t1_val_hi", val0, 1'b1);
      end else begin
        check("t1_val_lo", val0, 1'b0);
      end
    end

    // Priority list movement
    step(1, 0, 4'b0, 0);
    step(0, 1, 4'b1100, 0); check("t2_a", id0, 2'd2);
    step(0, 1, 4'b0000, 0);
    step(0, 1, 4'b1111, 0); check("t2_b", id0, 2'd0);
    step(0, 1, 4'b0000, 0);
    step(0, 1, 4'b0101, 0); check("t2_c", id0, 2'd2);

    // Lock held until done
    step(1, 0, 4'b0, 0);
    step(0, 1, 4'b0010, 0); check("t3_grant", gnt1, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 4'b0000, 0);
      check("t3_hold", gnt1, 4'b0010);
    end
    step(0, 1, 4'b0000, 1); check("t3_rel", gnt1, 4'b0000);
    step(0, 1, 4'b1111, 0); check("t3_next", id1, 2'd0);
    check("t3_next_v", val1, 1'b1);

    // Watchdog release after three held cycles
    step(1, 0, 4'b0, 0);
    step(0, 1, 4'b0001, 0); check("t4_g1", gnt2, 4'b0001);
    step(0, 1, 4'b1111, 0); check("t4_g2", gnt2, 4'b0001);
    step(0, 1, 4'b1111, 0); check("t4_g3", gnt2, 4'b0001);
    check("t4_to_lo", to2, 1'b0);
    step(0, 1, 4'b1111, 0); check("t4_rel", gnt2, 4'b0000);
    check("t4_to_hi", to2, 1'b1);
    step(0, 1, 4'b1111, 0); check("t4_next", gnt2, 4'b0010);
    check("t4_to_clr", to2, 1'b0);

    // Reset mid-grant restores the priority list
    step(1, 0, 4'b0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 4'b1111, 0);
    check("t5_pre", gnt0, 4'b1000);
    step(1, 1, 4'b1111, 0); check("t5_rst", gnt0, 4'b0000);
    step(0, 1, 4'b1111, 0); check("t5_id", id0, 2'd0);
    check("t5_val", val0, 1'b1);

    // Enable gating
    step(1, 0, 4'b0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 4'b1111, 0);
      check("t6_off", {val2, val1, val0}, 3'b000);
    end
    step(0, 1, 4'b1111, 0); check("t6_on", id0, 2'd0);
    check("t6_on_v", val0, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(urandom_bit(40), (urandom_range_wrap(0, 7) != 0),
           4'(urandom_range_wrap(0, 15)), (urandom_range_wrap(0, 3) == 0));
      check("onehot0", $countones(gnt0) <= 1, 1'b1);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic int urandom_range_wrap(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  function automatic logic urandom_bit(input int one_in);
    return ($urandom_range(one_in - 1, 0) == 0);
  endfunction

endmodule
